serial_subtractor: RTL and testbench

- Bit-serial WIDTH-bit subtractor computing A − B, LSB first, one bit per clock.
- Datapath is a single 1-bit full-subtractor cell plus a registered borrow: the borrow-propagating counterpart of the team's 1-bit full adder.
- Sits between an operand source and a result sink, with valid/ready handshakes on both sides.
- Trades latency (WIDTH cycles) for area, for tiny-tile designs.

---
 rtl/serial_arith_pkg.sv | 18 +
 rtl/full_subtractor_1b.sv | 15 +
 rtl/serial_subtractor.sv | 110 +++++++++++
 tb/tb_serial_subtractor.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks (subtractor now,
// adder/comparator later).
package serial_arith_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   localparam int WIDTH_DEFAULT = 8;

   // Borrow out of one bit position of x - y - bin.
   function automatic logic borrow_out(input logic x, input logic y, input logic bin);
      return (~x & y) | (~(x ^ y) & bin);
   endfunction

endpackage

// File: rtl/full_subtractor_1b.sv
// Combinational 1-bit full subtractor: d = x - y - bin, bout = borrow out.
module full_subtractor_1b
   import serial_arith_pkg::*;
(
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = x ^ y ^ bin;
   assign bout = borrow_out(x, y, bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B, LSB first, one bit per clock through a single full
// subtractor cell and a registered borrow, with valid/ready on both sides.
module serial_subtractor
   import serial_arith_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             zero
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_e           state;
   state_e           state_next;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] diff_sr;
   logic [WIDTH-1:0] diff_shifted;
   logic [CW-1:0]    cnt;
   logic             br;
   logic             d;
   logic             br_next;
   logic             last_bit;

   full_subtractor_1b u_cell (
      .x    (a_sr[0]),
      .y    (b_sr[0]),
      .bin  (br),
      .d    (d),
      .bout (br_next)
   );

   assign last_bit     = (cnt == LAST);
   assign diff_shifted = {d, diff_sr[WIDTH-1:1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (in_valid)  state_next = SHIFT;
         SHIFT:   if (last_bit)  state_next = DONE;
         DONE:    if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // borrow/zero are only latched on the final bit so they stay valid
   // from one result to the next; diff_sr restarts on every accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr    <= '0;
         b_sr    <= '0;
         diff_sr <= '0;
         cnt     <= '0;
         br      <= 1'b0;
         borrow  <= 1'b0;
         zero    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sr    <= a;
                  b_sr    <= b;
                  diff_sr <= '0;
                  cnt     <= '0;
                  br      <= 1'b0;
               end
            end
            SHIFT: begin
               a_sr    <= {1'b0, a_sr[WIDTH-1:1]};
               b_sr    <= {1'b0, b_sr[WIDTH-1:1]};
               diff_sr <= diff_shifted;
               br      <= br_next;
               if (last_bit) begin
                  cnt    <= '0;
                  borrow <= br_next;
                  zero   <= (diff_shifted == '0);
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign diff      = diff_sr;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: accepts push reference results,
// a negedge monitor pops and compares them on every presented result.
module tb_serial_subtractor;

   localparam int WIDTH  = 8;
   localparam int BUDGET = 200;

   typedef struct {
      logic [WIDTH-1:0] diff;
      logic             borrow;
      logic             zero;
      int               due;
   } exp_t;

   logic             clk       = 1'b1;
   logic             rst_n     = 1'b0;
   logic             in_valid  = 1'b0;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] a         = '0;
   logic [WIDTH-1:0] b         = '0;
   logic             in_ready;
   logic             out_valid;
   logic [WIDTH-1:0] diff;
   logic             borrow;
   logic             zero;

   int   checks   = 0;
   int   errors   = 0;
   int   ncyc     = 0;
   int   last_acc = 0;
   int   btb_cnt  = 0;
   bit   busy     = 1'b0;
   bit   prev_ov  = 1'b0;
   bit   rand_ready   = 1'b0;
   bit   forced_ready = 1'b1;
   bit   btb_mode     = 1'b0;
   exp_t exp_q[$];

   serial_subtractor #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .borrow    (borrow),
      .zero      (zero)
   );

   always #5 clk = ~clk;

   // Reference: plain modular arithmetic on the operand values.
   function automatic exp_t refModel(input int av, input int bv, input int due);
      exp_t e;
      int   m;
      int   dv;
      m        = 1 << WIDTH;
      dv       = (av - bv + m) % m;
      e.diff   = dv[WIDTH-1:0];
      e.borrow = (av < bv);
      e.zero   = (dv == 0);
      e.due    = due;
      return e;
   endfunction

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, ncyc);
      end
   endtask

   task automatic timeoutFail(input string what);
      $display("[TB] FAIL timeout %s: no DUT response within %0d cycles", what, BUDGET);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1, "[TB] stopping on timeout");
   endtask

   // Sink readiness: random during the soak phase, otherwise directed.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         out_ready = rand_ready ? 1'($urandom_range(0, 1)) : forced_ready;
      end
   end

   // Monitor and scoreboard, sampled mid-cycle on the falling edge.
   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_q.delete();
         busy    = 1'b0;
         prev_ov = 1'b0;
         btb_cnt = 0;
         if (!clk) begin
            checkOutput("reset_in_ready", int'(in_ready), 1);
            checkOutput("reset_out_valid", int'(out_valid), 0);
            checkOutput("reset_diff", int'(diff), 0);
            checkOutput("reset_borrow", int'(borrow), 0);
            checkOutput("reset_zero", int'(zero), 0);
         end
      end else begin
         ncyc++;
         checkOutput("in_ready", int'(in_ready), int'(!busy));
         if (exp_q.size() > 0 && ncyc == exp_q[0].due)
            checkOutput("out_valid_at_latency", int'(out_valid), 1);
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               checkOutput("unexpected_out_valid", int'(out_valid), 0);
            end else begin
               if (!prev_ov) checkOutput("latency", ncyc, exp_q[0].due);
               checkOutput("diff", int'(diff), int'(exp_q[0].diff));
               checkOutput("borrow", int'(borrow), int'(exp_q[0].borrow));
               checkOutput("zero", int'(zero), int'(exp_q[0].zero));
               if (out_ready) begin
                  void'(exp_q.pop_front());
                  busy = 1'b0;
               end
            end
         end
         prev_ov = out_valid;
         if (!btb_mode) btb_cnt = 0;
         if (in_valid && in_ready) begin
            exp_q.push_back(refModel(int'(a), int'(b), ncyc + 1 + WIDTH));
            busy = 1'b1;
            if (btb_mode) begin
               if (btb_cnt > 0) checkOutput("accept_spacing", ncyc - last_acc, WIDTH + 2);
               btb_cnt++;
            end
            last_acc = ncyc;
         end
      end
   end

   // Called just after a rising edge; returns just after the accept edge.
   task automatic applyStimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input bit hold);
      int n;
      a        = av;
      b        = bv;
      in_valid = 1'b1;
      n        = 0;
      while (n < BUDGET) begin
         @(negedge clk);
         if (in_ready) break;
         n++;
      end
      if (n >= BUDGET) timeoutFail("accept");
      @(posedge clk);
      #1;
      if (!hold) in_valid = 1'b0;
   endtask

   task automatic waitIdle();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(in_ready && !out_valid && exp_q.size() == 0) && n < BUDGET);
      if (n >= BUDGET) timeoutFail("drain");
      @(posedge clk);
      #1;
   endtask

   task automatic waitOutValid();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid && n < BUDGET);
      if (n >= BUDGET) timeoutFail("out_valid");
   endtask

   task automatic pulseReset();
      #2;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Directed cases, sink always ready.
      applyStimulus(8'h05, 8'h03, 1'b0); waitIdle();
      applyStimulus(8'h03, 8'h05, 1'b0); waitIdle();
      applyStimulus(8'h00, 8'h01, 1'b0); waitIdle();

      // Asynchronous reset four cycles into a shift; result must vanish.
      applyStimulus(8'h10, 8'h01, 1'b0);
      repeat (4) @(posedge clk);
      pulseReset();
      applyStimulus(8'h10, 8'h01, 1'b0); waitIdle();

      applyStimulus(8'h80, 8'h80, 1'b0); waitIdle();
      applyStimulus(8'hFF, 8'h00, 1'b0); waitIdle();
      applyStimulus(8'h00, 8'hFF, 1'b0); waitIdle();

      // Backpressure for five DONE cycles with a competing operand offer.
      forced_ready = 1'b0;
      applyStimulus(8'h5A, 8'h33, 1'b0);
      waitOutValid();
      repeat (4) begin
         @(posedge clk);
         #1;
         a        = 8'h11;
         b        = 8'h22;
         in_valid = 1'b1;
      end
      @(posedge clk);
      #1;
      in_valid     = 1'b0;
      forced_ready = 1'b1;
      waitIdle();

      // Reset while a zero result is held in DONE.
      forced_ready = 1'b0;
      applyStimulus(8'h33, 8'h33, 1'b0);
      waitOutValid();
      @(posedge clk);
      pulseReset();
      forced_ready = 1'b1;
      waitIdle();

      // in_valid held high across three operand pairs.
      btb_mode = 1'b1;
      applyStimulus(8'h12, 8'h34, 1'b1);
      applyStimulus(8'hA0, 8'h0B, 1'b1);
      applyStimulus(8'h7F, 8'h80, 1'b0);
      waitIdle();
      btb_mode = 1'b0;

      // Random operands with a randomly stalling sink.
      rand_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         logic [WIDTH-1:0] ra;
         logic [WIDTH-1:0] rb;
         ra = WIDTH'($urandom);
         rb = WIDTH'($urandom);
         case ($urandom_range(0, 5))
            0: rb = ra;
            1: begin ra = '0; rb = '1; end
            default: begin end
         endcase
         applyStimulus(ra, rb, 1'b0);
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
      end
      rand_ready = 1'b0;
      waitIdle();
      repeat (3) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
